// File: rtl/regfile_sb.sv
// regfile_sb: register file with two byte-enabled write ports, two combinational read
// ports and a busy scoreboard that tracks registers with a pending result.
//
// Ports:
//   i_clk, i_rstn                    clock, asynchronous active-low reset
//   i_rf_wr_en{0,1}                  write enables
//   i_rf_wr_addr{0,1}                write addresses
//   i_rf_wr_data{0,1}                write data
//   i_rf_wr_be{0,1}                  byte enables, bit k selects byte k
//   i_rf_rd_addr{0,1}                read addresses
//   o_rf_rd_data{0,1}                read data (combinational)
//   o_rf_rd_rdy{0,1}                 read operand not pending
//   i_sb_set_en, i_sb_set_addr       mark a register busy
//   o_sb_busy                        registered busy vector
//   o_sb_err                         one-cycle pulse on a reservation of a busy register
module regfile_sb #(
    parameter int unsigned BW_DATA  = 32,
    parameter int unsigned BW_ADDR  = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_rf_wr_en0,
    input  logic                    i_rf_wr_en1,
    input  logic [BW_ADDR-1:0]      i_rf_wr_addr0,
    input  logic [BW_ADDR-1:0]      i_rf_wr_addr1,
    input  logic [BW_DATA-1:0]      i_rf_wr_data0,
    input  logic [BW_DATA-1:0]      i_rf_wr_data1,
    input  logic [BW_DATA/8-1:0]    i_rf_wr_be0,
    input  logic [BW_DATA/8-1:0]    i_rf_wr_be1,
    input  logic [BW_ADDR-1:0]      i_rf_rd_addr0,
    input  logic [BW_ADDR-1:0]      i_rf_rd_addr1,
    output logic [BW_DATA-1:0]      o_rf_rd_data0,
    output logic [BW_DATA-1:0]      o_rf_rd_data1,
    output logic                    o_rf_rd_rdy0,
    output logic                    o_rf_rd_rdy1,
    input  logic                    i_sb_set_en,
    input  logic [BW_ADDR-1:0]      i_sb_set_addr,
    output logic [2**BW_ADDR-1:0]   o_sb_busy,
    output logic                    o_sb_err
);

    localparam int unsigned Depth    = 2**BW_ADDR;
    localparam int unsigned NumBytes = BW_DATA / 8;

    logic [BW_DATA-1:0] mem_q [Depth];
    logic [BW_DATA-1:0] mem_d [Depth];
    logic [Depth-1:0]   busy_q, busy_d;
    logic [Depth-1:0]   set_vec, clr_vec;
    logic               err_q, err_d;
    logic               wr_en0, wr_en1, set_en;

    // Gating with the reset input keeps held-in-reset writes out of the bypass path too.
    assign wr_en0 = i_rf_wr_en0 & i_rstn;
    assign wr_en1 = i_rf_wr_en1 & i_rstn;
    assign set_en = i_sb_set_en & i_rstn;

    // Post-write value of every entry; doubles as the bypass source for reads.
    always_comb begin
        for (int e = 0; e < Depth; e++) begin
            mem_d[e] = mem_q[e];
            for (int b = 0; b < NumBytes; b++) begin
                if (wr_en0 && i_rf_wr_addr0 == BW_ADDR'(e) && i_rf_wr_be0[b]) begin
                    mem_d[e][8*b +: 8] = i_rf_wr_data0[8*b +: 8];
                end
                // Port 1 is applied last so it wins a byte both ports enable.
                if (wr_en1 && i_rf_wr_addr1 == BW_ADDR'(e) && i_rf_wr_be1[b]) begin
                    mem_d[e][8*b +: 8] = i_rf_wr_data1[8*b +: 8];
                end
            end
        end
        if (ZERO_REG) begin
            mem_d[0] = '0;
        end
    end

    // Scoreboard: any enabled write clears (even with no byte enables), a set wins over a clear.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int e = 0; e < Depth; e++) begin
            set_vec[e] = set_en && (i_sb_set_addr == BW_ADDR'(e));
            clr_vec[e] = (wr_en0 && (i_rf_wr_addr0 == BW_ADDR'(e)))
                       || (wr_en1 && (i_rf_wr_addr1 == BW_ADDR'(e)));
        end
        if (ZERO_REG) begin
            set_vec[0] = 1'b0;
        end
        busy_d = (busy_q & ~clr_vec) | set_vec;
        // Reserving a register whose producer is still outstanding is an error.
        err_d  = |(set_vec & busy_q & ~clr_vec);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int e = 0; e < Depth; e++) begin
                mem_q[e] <= '0;
            end
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int e = 0; e < Depth; e++) begin
                mem_q[e] <= mem_d[e];
            end
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        if (BYPASS) begin
            o_rf_rd_data0 = mem_d[i_rf_rd_addr0];
            o_rf_rd_data1 = mem_d[i_rf_rd_addr1];
        end else begin
            o_rf_rd_data0 = mem_q[i_rf_rd_addr0];
            o_rf_rd_data1 = mem_q[i_rf_rd_addr1];
        end
        if (ZERO_REG && i_rf_rd_addr0 == '0) begin
            o_rf_rd_data0 = '0;
        end
        if (ZERO_REG && i_rf_rd_addr1 == '0) begin
            o_rf_rd_data1 = '0;
        end
    end

    always_comb begin
        o_rf_rd_rdy0 = !busy_q[i_rf_rd_addr0] || (BYPASS && clr_vec[i_rf_rd_addr0]);
        o_rf_rd_rdy1 = !busy_q[i_rf_rd_addr1] || (BYPASS && clr_vec[i_rf_rd_addr1]);
        if (ZERO_REG && i_rf_rd_addr0 == '0) begin
            o_rf_rd_rdy0 = 1'b1;
        end
        if (ZERO_REG && i_rf_rd_addr1 == '0) begin
            o_rf_rd_rdy1 = 1'b1;
        end
    end

    assign o_sb_busy = busy_q;
    assign o_sb_err  = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives two register files from the same stimulus, one with the default
// configuration (zero register, bypass) and one with ZERO_REG=0, BYPASS=0, and checks both
// against a behavioural model every cycle plus literal expectations for the key scenarios.
module tb_regfile_sb;

    localparam int D = 32;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        wr_en0, wr_en1;
    logic [4:0]  wr_addr0, wr_addr1, rd_addr0, rd_addr1, set_addr;
    logic [31:0] wr_data0, wr_data1;
    logic [3:0]  wr_be0, wr_be1;
    logic        sb_set_en;

    logic [31:0] rd_data0 [2];
    logic [31:0] rd_data1 [2];
    logic        rd_rdy0  [2];
    logic        rd_rdy1  [2];
    logic [31:0] sb_busy  [2];
    logic        sb_err   [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    always #5 i_clk = ~i_clk;

    regfile_sb dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_rf_wr_en0(wr_en0), .i_rf_wr_en1(wr_en1),
        .i_rf_wr_addr0(wr_addr0), .i_rf_wr_addr1(wr_addr1),
        .i_rf_wr_data0(wr_data0), .i_rf_wr_data1(wr_data1),
        .i_rf_wr_be0(wr_be0), .i_rf_wr_be1(wr_be1),
        .i_rf_rd_addr0(rd_addr0), .i_rf_rd_addr1(rd_addr1),
        .o_rf_rd_data0(rd_data0[0]), .o_rf_rd_data1(rd_data1[0]),
        .o_rf_rd_rdy0(rd_rdy0[0]), .o_rf_rd_rdy1(rd_rdy1[0]),
        .i_sb_set_en(sb_set_en), .i_sb_set_addr(set_addr),
        .o_sb_busy(sb_busy[0]), .o_sb_err(sb_err[0])
    );

    regfile_sb #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_nb (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_rf_wr_en0(wr_en0), .i_rf_wr_en1(wr_en1),
        .i_rf_wr_addr0(wr_addr0), .i_rf_wr_addr1(wr_addr1),
        .i_rf_wr_data0(wr_data0), .i_rf_wr_data1(wr_data1),
        .i_rf_wr_be0(wr_be0), .i_rf_wr_be1(wr_be1),
        .i_rf_rd_addr0(rd_addr0), .i_rf_rd_addr1(rd_addr1),
        .o_rf_rd_data0(rd_data0[1]), .o_rf_rd_data1(rd_data1[1]),
        .o_rf_rd_rdy0(rd_rdy0[1]), .o_rf_rd_rdy1(rd_rdy1[1]),
        .i_sb_set_en(sb_set_en), .i_sb_set_addr(set_addr),
        .o_sb_busy(sb_busy[1]), .o_sb_err(sb_err[1])
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model; config 0 = zero reg + bypass, 1 = neither ----------
    logic [31:0] mem_m  [2][D];
    logic [D-1:0] busy_m [2];
    logic        err_m  [2];

    function automatic bit written(int a);
        return (wr_en0 && int'(wr_addr0) == a) || (wr_en1 && int'(wr_addr1) == a);
    endfunction

    // Value entry a holds after this cycle's writes (port 1 overrides port 0 per byte).
    function automatic logic [31:0] merged(int c, int a);
        logic [31:0] v;
        v = mem_m[c][a];
        for (int b = 0; b < 4; b++) begin
            if (wr_en0 && int'(wr_addr0) == a && wr_be0[b]) v[8*b +: 8] = wr_data0[8*b +: 8];
        end
        for (int b = 0; b < 4; b++) begin
            if (wr_en1 && int'(wr_addr1) == a && wr_be1[b]) v[8*b +: 8] = wr_data1[8*b +: 8];
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_rd(int c, int a);
        if (!i_rstn) return 32'h0;
        if (c == 0 && a == 0) return 32'h0;
        if (c == 0) return merged(c, a);
        return mem_m[c][a];
    endfunction

    function automatic logic exp_rdy(int c, int a);
        if (!i_rstn) return 1'b1;
        if (c == 0 && a == 0) return 1'b1;
        if (c == 0 && written(a)) return 1'b1;
        return !busy_m[c][a];
    endfunction

    always @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int c = 0; c < 2; c++) begin
                for (int e = 0; e < D; e++) mem_m[c][e] <= 32'h0;
                busy_m[c] <= '0;
                err_m[c]  <= 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                for (int e = 0; e < D; e++) begin
                    if (!(c == 0 && e == 0)) mem_m[c][e] <= merged(c, e);
                    busy_m[c][e] <= (sb_set_en && int'(set_addr) == e && !(c == 0 && e == 0))
                                    || (busy_m[c][e] && !written(e));
                end
                err_m[c] <= sb_set_en && busy_m[c][set_addr] && !written(int'(set_addr))
                            && !(c == 0 && set_addr == 5'd0);
            end
        end
    end

    // Compare process: every output of both instances, every cycle.
    always @(negedge i_clk) begin
        if (cmp_on) begin
            for (int c = 0; c < 2; c++) begin
                check(c == 0 ? "rd_data0" : "nb_rd_data0", rd_data0[c], exp_rd(c, int'(rd_addr0)));
                check(c == 0 ? "rd_data1" : "nb_rd_data1", rd_data1[c], exp_rd(c, int'(rd_addr1)));
                check(c == 0 ? "rd_rdy0" : "nb_rd_rdy0", rd_rdy0[c], exp_rdy(c, int'(rd_addr0)));
                check(c == 0 ? "rd_rdy1" : "nb_rd_rdy1", rd_rdy1[c], exp_rdy(c, int'(rd_addr1)));
                check(c == 0 ? "sb_busy" : "nb_sb_busy", sb_busy[c], busy_m[c]);
                check(c == 0 ? "sb_err" : "nb_sb_err", sb_err[c], err_m[c]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_inputs();
        wr_en0 = 0; wr_en1 = 0; wr_addr0 = 0; wr_addr1 = 0; wr_data0 = 0; wr_data1 = 0;
        wr_be0 = 0; wr_be1 = 0; rd_addr0 = 0; rd_addr1 = 0; sb_set_en = 0; set_addr = 0;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
        clear_inputs();
    endtask

    function automatic logic [4:0] pick_addr();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        clear_inputs();
        i_rstn = 1'b1;
        #2 i_rstn = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_busy", sb_busy[0], 32'h0);
        check("reset_err", sb_err[0], 1'b0);
        check("reset_rd", rd_data0[1], 32'h0);
        @(posedge i_clk);
        #1 i_rstn = 1'b1;
        cmp_on = 1'b1;

        // Byte merge
        wr_en0 = 1; wr_addr0 = 3; wr_data0 = 32'h11223344; wr_be0 = 4'b1111;
        next_cycle();
        wr_en0 = 1; wr_addr0 = 3; wr_data0 = 32'hAABBCCDD; wr_be0 = 4'b0101; rd_addr0 = 3;
        @(negedge i_clk);
        check("merge_bypass", rd_data0[0], 32'h11BB33DD);
        check("merge_nobypass", rd_data0[1], 32'h11223344);
        next_cycle();
        rd_addr0 = 3;
        @(negedge i_clk);
        check("merge", rd_data0[0], 32'h11BB33DD);
        check("nb_merge", rd_data0[1], 32'h11BB33DD);

        // Dual-port collision
        next_cycle();
        wr_en0 = 1; wr_addr0 = 5; wr_data0 = 32'h0; wr_be0 = 4'b1111;
        wr_en1 = 1; wr_addr1 = 5; wr_data1 = 32'hFFFFFFFF; wr_be1 = 4'b0011;
        next_cycle();
        rd_addr1 = 5;
        @(negedge i_clk);
        check("collision", rd_data1[0], 32'h0000FFFF);
        check("nb_collision", rd_data1[1], 32'h0000FFFF);

        // Bypass
        next_cycle();
        wr_en0 = 1; wr_addr0 = 7; wr_data0 = 32'h12345678; wr_be0 = 4'b1111;
        next_cycle();
        rd_addr0 = 7; wr_en1 = 1; wr_addr1 = 7; wr_data1 = 32'hCAFEF00D; wr_be1 = 4'b1111;
        @(negedge i_clk);
        check("bypass", rd_data0[0], 32'hCAFEF00D);
        check("nb_bypass_old", rd_data0[1], 32'h12345678);

        // Scoreboard set / clear / set-wins
        next_cycle();
        sb_set_en = 1; set_addr = 9;
        next_cycle();
        rd_addr0 = 9;
        @(negedge i_clk);
        check("busy9_set", sb_busy[0][9], 1'b1);
        check("rdy9_busy", rd_rdy0[0], 1'b0);
        next_cycle();
        rd_addr0 = 9; wr_en0 = 1; wr_addr0 = 9; wr_data0 = 32'h99; wr_be0 = 4'b1111;
        @(negedge i_clk);
        check("rdy9_bypass", rd_rdy0[0], 1'b1);
        check("nb_rdy9_nobypass", rd_rdy0[1], 1'b0);
        next_cycle();
        @(negedge i_clk);
        check("busy9_clear", sb_busy[0][9], 1'b0);
        next_cycle();
        sb_set_en = 1; set_addr = 9; wr_en1 = 1; wr_addr1 = 9; wr_be1 = 4'b0000;
        next_cycle();
        @(negedge i_clk);
        check("busy9_set_wins", sb_busy[0][9], 1'b1);
        check("no_err_set_wins", sb_err[0], 1'b0);

        // Double reservation and zero register
        next_cycle();
        sb_set_en = 1; set_addr = 4;
        next_cycle();
        sb_set_en = 1; set_addr = 4;
        @(negedge i_clk);
        check("err_before", sb_err[0], 1'b0);
        next_cycle();
        @(negedge i_clk);
        check("err_pulse", sb_err[0], 1'b1);
        check("busy4_held", sb_busy[0][4], 1'b1);
        next_cycle();
        @(negedge i_clk);
        check("err_one_cycle", sb_err[0], 1'b0);
        sb_set_en = 1; set_addr = 0;
        next_cycle();
        @(negedge i_clk);
        check("busy0_never", sb_busy[0][0], 1'b0);
        check("err_zero_reg", sb_err[0], 1'b0);
        check("nb_busy0_set", sb_busy[1][0], 1'b1);

        // Asynchronous reset between edges
        next_cycle();
        sb_set_en = 1; set_addr = 2;
        next_cycle();
        rd_addr0 = 3; rd_addr1 = 5;
        check("busy2_before_rst", sb_busy[0][2], 1'b1);
        #2 i_rstn = 1'b0;
        #1;
        check("rst_rd0", rd_data0[0], 32'h0);
        check("rst_rd1", rd_data1[1], 32'h0);
        check("rst_busy", sb_busy[0], 32'h0);
        check("rst_err", sb_err[0], 1'b0);
        check("rst_rdy", rd_rdy0[1], 1'b1);
        @(posedge i_clk);
        #1 i_rstn = 1'b1;

        // Randomized traffic with occasional mid-cycle resets
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            i_rstn    = 1'b1;
            wr_en0    = 1'($urandom_range(0, 1));
            wr_en1    = 1'($urandom_range(0, 1));
            wr_addr0  = pick_addr();
            wr_addr1  = pick_addr();
            wr_data0  = $urandom;
            wr_data1  = $urandom;
            wr_be0    = 4'($urandom);
            wr_be1    = 4'($urandom);
            rd_addr0  = pick_addr();
            rd_addr1  = pick_addr();
            sb_set_en = 1'($urandom_range(0, 1));
            set_addr  = pick_addr();
            if ($urandom_range(0, 199) == 0) begin
                #2 i_rstn = 1'b0;
            end
        end

        next_cycle();
        i_rstn = 1'b1;
        @(negedge i_clk);
        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter BW_DATA, default 32, data width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter BW_ADDR, default 5, address width; depth is 2**BW_ADDR entries.
REQ-003 SHALL have parameter ZERO_REG, default 1; 1 makes entry 0 hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1; 1 forwards same-cycle writes to reads.
REQ-005 SHALL have one clock; reset is asynchronous and active-low: i_clk input 1, rising-edge clock.
REQ-006 SHALL have i_rstn  input  1  asynchronous active-low reset.
REQ-007 SHALL have i_rf_wr_en0/i_rf_wr_en1  input  1 each  write enables, ports 0 and 1.
REQ-008 SHALL have i_rf_wr_addr0/i_rf_wr_addr1  input  BW_ADDR each  write addresses.
REQ-009 SHALL have i_rf_wr_data0/i_rf_wr_data1  input  BW_DATA each  write data.
REQ-010 SHALL have i_rf_wr_be0/i_rf_wr_be1  input  BW_DATA/8 each  byte enables; bit k selects byte k.
REQ-011 SHALL have i_rf_rd_addr0/i_rf_rd_addr1  input  BW_ADDR each  read addresses.
REQ-012 SHALL have o_rf_rd_data0/o_rf_rd_data1  output  BW_DATA each  read data.
REQ-013 SHALL have o_rf_rd_rdy0/o_rf_rd_rdy1  output  1 each  read operand valid, i.e. not pending.
REQ-014 SHALL have i_sb_set_en  input  1  mark a register busy, meaning a result is pending.
REQ-015 SHALL have i_sb_set_addr  input  BW_ADDR  register to mark busy.
REQ-016 SHALL have o_sb_busy  output  2**BW_ADDR  registered busy vector.
REQ-017 SHALL have o_sb_err  output  1  registered one-cycle pulse on a double reservation.

Function
REQ-018 Write: on a rising edge with i_rf_wr_enN=1, bytes of entry i_rf_wr_addrN whose be bit is 1 SHALL take i_rf_wr_dataN; other bytes are held.
REQ-019 Both ports enabled to the same address SHALL merge per byte; port 1 wins a byte both enable.
REQ-020 Write with be all-zero SHALL leave data unchanged but still count as a write for REQ-025.
REQ-021 Read SHALL be combinational: o_rf_rd_dataN = entry[i_rf_rd_addrN], zero latency.
REQ-022 With BYPASS=1, a read matching an enabled write address in the same cycle SHALL return the post-write merged value per REQ-018..019; with BYPASS=0 it SHALL return the pre-edge value.
REQ-023 With ZERO_REG=1, reads of address 0 SHALL return 0, writes to 0 SHALL be ignored, and busy[0] SHALL never set; the bypass of address 0 SHALL also return 0.
REQ-024 Scoreboard set: i_sb_set_en=1 SHALL set busy[i_sb_set_addr] on the next edge.
REQ-025 Any enabled write, port 0 or 1, SHALL clear busy[addr] on the next edge.
REQ-026 Set and write-clear on the same address in one cycle: set SHALL win, so busy stays or becomes 1, because a new producer has been issued.
REQ-027 i_sb_set_en to an address already busy and not cleared that cycle SHALL assert o_sb_err for exactly the next cycle; busy stays 1.
REQ-028 o_rf_rd_rdyN SHALL equal !busy[addr], or, with BYPASS=1, 1 when an enabled write to that addr occurs this cycle; address 0 with ZERO_REG=1 SHALL always be ready.
REQ-029 Outputs SHALL contain no X for any in-range input after reset; the address space is fully decoded with no out-of-range case.

Reset
REQ-030 i_rstn=0 SHALL asynchronously clear all entries to 0, all busy bits to 0, and o_sb_err to 0, independent of i_clk.
REQ-031 While i_rstn=0, writes and sets SHALL be ignored; reads return 0 and rdy is 1.
REQ-032 Deassertion SHALL take effect from the first rising edge with i_rstn=1; reset mid-operation SHALL discard any pending reservation.

Verification
REQ-033 Byte merge: wr0 addr3 data 0x11223344 be 1111, then wr0 addr3 data 0xAABBCCDD be 0101 -> rd addr3 = 0x11BB33DD.
REQ-034 Dual-port collision: wr0 addr5 0x00000000 be 1111 and wr1 addr5 0xFFFFFFFF be 0011 in the same cycle -> next-cycle read 0x0000FFFF.
REQ-035 Bypass: rd0 addr7 while wr1 addr7 0xCAFEF00D be 1111 -> same-cycle o_rf_rd_data0=0xCAFEF00D with BYPASS=1, and the old value with BYPASS=0.
REQ-036 Scoreboard: set addr9 -> busy[9]=1 and rdy for addr9=0; wr addr9 -> same cycle rdy=1 with BYPASS=1, next cycle busy[9]=0; set and wr addr9 together -> busy[9]=1.
REQ-037 Error: set addr4 twice on consecutive cycles -> o_sb_err=1 for one cycle only; set addr0 with ZERO_REG=1 -> busy[0]=0 and no error.
REQ-038 Async reset: fill entries, set busy[2], pulse i_rstn low between edges -> all reads 0, o_sb_busy=0, o_sb_err=0 immediately.
